nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NIBBLES = WIDTH/4, the number of add cycles per operation.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in of the least significant nibble.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  WIDTH  result, in_a + in_b + in_cin modulo 2^WIDTH.
REQ-013 out_cout  output  1  carry-out of the most significant nibble.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); in_valid outside IDLE SHALL be ignored with no side effects.
REQ-017 On an edge with in_valid&&in_ready, the block SHALL capture in_a, in_b and in_cin, set the carry register to in_cin, clear the nibble index, and go to ADD.
REQ-018 Each ADD cycle SHALL add nibble[idx] of A and B with the carry register, write the 4-bit sum into out_sum[4*idx+3:4*idx], load the nibble carry-out into the carry register, and increment idx.
REQ-019 When idx==NIBBLES-1 in ADD, the block SHALL transition to DONE, drive out_cout with the final carry, and assert out_valid.
REQ-020 out_valid SHALL rise exactly NIBBLES edges after the accepting edge; for WIDTH=16 this is 4 edges.
REQ-021 In DONE, out_sum, out_cout and out_valid SHALL be held stable until out_valid&&out_ready; on that edge the FSM SHALL return to IDLE and deassert out_valid.
REQ-022 The next operand SHALL NOT be accepted on the same edge as result hand-off; in_ready rises the cycle after.
REQ-023 out_sum bits not yet written in ADD SHALL read 0; out_sum is qualified only by out_valid.
REQ-024 There SHALL be no combinational path from in_* to out_*.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL go to IDLE, and clear out_valid, out_sum, out_cout, the carry register and idx to 0; busy SHALL read 0.
REQ-026 rst SHALL take priority over every handshake, and a reset during ADD or DONE SHALL silently abort the operation.
REQ-027 On the first edge after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-028 Macro NIBBLE_SERIAL_ADDER_OVF_EN, when defined, SHALL add output port out_ovf (1 bit): signed two's-complement overflow, computed as carry-into-MSB XOR carry-out-of-MSB, registered and valid with out_valid, and reset to 0.
REQ-029 Without NIBBLE_SERIAL_ADDER_OVF_EN, the out_ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The state encoding (IDLE/ADD/DONE) and the nibble width constant 4 SHALL live in the shared package nibble_adder_pkg.
REQ-031 One sub-module, nibble_adder, SHALL perform the combinational 4-bit add (a[3:0], b[3:0], cin -> sum[3:0], cout, carry-into-MSB), and SHALL be instantiated once.

Verification
REQ-032 WIDTH=16, A=0x0003, B=0x0005, cin=0, out_ready=1 -> out_sum=0x0008, out_cout=0, with out_valid rising 4 edges after accept.
REQ-033 A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1; with OVF_EN, out_ovf=0.
REQ-034 A=0x7FFF, B=0x0001, cin=0, with OVF_EN -> out_sum=0x8000, out_cout=0, out_ovf=1.
REQ-035 A=0x00FA, B=0x0006, cin=1 with out_ready=0 for 5 cycles -> out_valid held with out_sum=0x0101 stable; new in_valid pulses are ignored; result is delivered on out_ready=1.
REQ-036 rst asserted on the 2nd ADD cycle -> next cycle out_valid=0, out_sum=0, busy=0, in_ready=1; a following add of 0x1234+0x1111 yields 0x2345.
REQ-037 Back-to-back operations with in_valid held high -> each result is accepted, and in_ready=0 on the hand-off edge.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder slice; also exposes the carry into the MSB for
// signed-overflow detection.
module nibble_adder
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout,
    output logic                o_c_msb
);

    logic [NIBBLE_W-1:0] w_low;
    logic [1:0]          w_high;

    // Low bits plus their carry; the top bit of w_low is the carry into the MSB.
    assign w_low   = {1'b0, i_a[NIBBLE_W-2:0]} + {1'b0, i_b[NIBBLE_W-2:0]}
                   + {{(NIBBLE_W-1){1'b0}}, i_cin};
    assign o_c_msb = w_low[NIBBLE_W-1];
    assign w_high  = {1'b0, i_a[NIBBLE_W-1]} + {1'b0, i_b[NIBBLE_W-1]} + {1'b0, o_c_msb};

    assign o_sum  = {w_high[0], w_low[NIBBLE_W-2:0]};
    assign o_cout = w_high[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a shared 4-bit slice.
// Optional out_ovf (signed overflow) port enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic                w_c_msb;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .i_a     (w_a_nib),
        .i_b     (w_b_nib),
        .i_cin   (r_carry),
        .o_sum   (w_nib_sum),
        .o_cout  (w_nib_cout),
        .o_c_msb (w_c_msb)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (in_valid)  w_state_next = StAdd;
            StAdd:   if (w_last)    w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default:                w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                StAdd: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout <= w_nib_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == StAdd && w_last) begin
            r_ovf <= w_c_msb ^ w_nib_cout;
        end
    end

    assign out_ovf = r_ovf;
`else
    logic w_unused_c_msb;
    assign w_unused_c_msb = w_c_msb;
`endif

    assign in_ready  = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign out_valid = (r_state == StDone);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed table,
// reset-abort and back-to-back sequences, and randomized operations.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          hold;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                  output logic [15:0] s, output logic c, output logic v);
        logic [31:0] u;
        int          sg;
        u  = 32'(a) + 32'(b) + 32'(cin);
        s  = u[15:0];
        c  = u[16];
        sg = int'($signed(a)) + int'($signed(b)) + int'(cin);
        v  = (sg > 32767) || (sg < -32768);
    endfunction

    // Called at a negedge; returns at the negedge after the hand-off edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold, input bit keep,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        int edges;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("accept_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        if (keep) begin
            in_a   = 16'($urandom);
            in_b   = 16'($urandom);
            in_cin = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("partial_sum_zero", 32'(out_sum), 0);
        chk("busy_in_add", 32'(busy), 1);
        chk("ready_low_in_add", 32'(in_ready), 0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", 32'(edges), NIBBLES);
        chk("sum", 32'(out_sum), 32'(esum));
        chk("cout", 32'(out_cout), 32'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("ovf", 32'(out_ovf), 32'(eovf));
`else
        if (eovf === 1'bx) chk("ovf_arg", 32'(eovf), 0);
`endif
        chk("ready_low_done", 32'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("held_valid", 32'(out_valid), 1);
            chk("held_sum", 32'(out_sum), 32'(esum));
            chk("held_cout", 32'(out_cout), 32'(ecout));
        end
        out_ready = 1'b1;
        in_valid  = keep;
        @(posedge clk);
        @(negedge clk);
        chk("valid_low_after_handoff", 32'(out_valid), 0);
        chk("ready_after_handoff", 32'(in_ready), 1);
        chk("idle_after_handoff", 32'(busy), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        c;
        logic        v;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        // Reset has priority over a pending handshake.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'hFFFF;
        in_b      = 16'hFFFF;
        in_cin    = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_cout", 32'(out_cout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("rst_out_ovf", 32'(out_ovf), 0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 1);

        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 0, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h00FA, 16'h0006, 1'b1, 5, 16'h0101, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, 0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0};
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, 1'b0,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Back-to-back with in_valid held high throughout.
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, s, c, v);
            run_op(ra, rb, rc, 0, (i != 3), s, c, v);
        end
        in_valid = 1'b0;

        // Reset during the second ADD cycle aborts the operation.
        in_a      = 16'hABCD;
        in_b      = 16'h1111;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_before_abort", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_out_sum", 32'(out_sum), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0, 16'h2345, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, s, c, v);
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), 1'b0, s, c, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
